// File: rtl/regs_mp_sb_pkg.sv
// Shared constants and JTAG port state encoding for the regs_mp_sb register file.
package regs_mp_sb_pkg;

  localparam int          ZeroReg     = 0;
  localparam logic [63:0] ZeroWord    = '0;
  localparam logic        WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    JTAG_IDLE = 2'b00,
    JTAG_EXEC = 2'b01,
    JTAG_ACK  = 2'b10,
    JTAG_DROP = 2'b11
  } jtag_state_e;

endpackage

// File: rtl/regs_jtag_port.sv
// JTAG access port: request latch, access FSM, read-data register, write request to the storage core.
// REGS_JTAG_HOLD_EN adds a blocked-cycle counter that raises hold toward the core.
module regs_jtag_port
  import regs_mp_sb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int AW            = 5,
  parameter int JTAG_WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_req,
  input  logic              jtag_we,
  input  logic [AW-1:0]     jtag_addr,
  input  logic [XLEN-1:0]   jtag_data,
  output logic              jtag_ack,
  output logic [XLEN-1:0]   rdata,
  output logic              hold,
  output logic [AW-1:0]     acc_addr,
  input  logic [XLEN-1:0]   acc_rdata,
  output logic              wr_req,
  output logic [XLEN-1:0]   wr_data,
  input  logic              wr_gnt,
  output jtag_state_e       state
);

  // Handshake: jtag_req is a level held by the debugger until it sees the one-cycle
  // jtag_ack pulse; it must then drop req for at least one cycle before the next access.

  if (JTAG_WAIT_MAX < 1) begin : g_bad_wait
    $error("JTAG_WAIT_MAX must be at least 1");
  end

  jtag_state_e          state_next;
  logic                 lat_we;
  logic [AW-1:0]        lat_addr;
  logic [XLEN-1:0]      lat_data;
  logic                 to_x0;

  assign to_x0 = (lat_addr == AW'(ZeroReg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= JTAG_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (state == JTAG_IDLE && jtag_req) begin
      lat_we   <= jtag_we;
      lat_addr <= jtag_addr;
      lat_data <= jtag_data;
    end
  end

  // Reads return committed state only; the core's write bypass is deliberately not used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             rdata <= '0;
    else if (state == JTAG_EXEC && !lat_we) rdata <= acc_rdata;
  end

  always_comb begin
    state_next = state;
    case (state)
      JTAG_IDLE: if (jtag_req) state_next = JTAG_EXEC;
      JTAG_EXEC: if (!lat_we || to_x0 || wr_gnt) state_next = JTAG_ACK;
      JTAG_ACK:  state_next = JTAG_DROP;
      JTAG_DROP: if (!jtag_req) state_next = JTAG_IDLE;
      default:   state_next = JTAG_IDLE;
    endcase
  end

`ifdef REGS_JTAG_HOLD_EN
  localparam int CW = $clog2(JTAG_WAIT_MAX + 1);
  logic [CW-1:0] blk_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         blk_cnt <= '0;
    else if (state != JTAG_EXEC)                      blk_cnt <= '0;
    else if (wr_req && !wr_gnt && blk_cnt != CW'(JTAG_WAIT_MAX)) blk_cnt <= blk_cnt + 1'b1;
  end
`endif

  always_comb begin
    jtag_ack = (state == JTAG_ACK);
    wr_req   = (state == JTAG_EXEC) && lat_we && !to_x0;
    acc_addr = lat_addr;
    wr_data  = lat_data;
`ifdef REGS_JTAG_HOLD_EN
    hold     = (state == JTAG_EXEC) && (blk_cnt == CW'(JTAG_WAIT_MAX));
`else
    hold     = 1'b0;
`endif
  end

endmodule

// File: rtl/regs_mp_sb.sv
// Register file with NRD bypassing read ports, one core write port, busy scoreboard and JTAG access.
// REGS_JTAG_HOLD_EN enables the JTAG hold request (see regs_jtag_port).
module regs_mp_sb
  import regs_mp_sb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter int NRD           = 2,
  parameter int JTAG_WAIT_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we_i,
  input  logic [$clog2(NREGS)-1:0]      waddr_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [NRD*$clog2(NREGS)-1:0]  raddr_i,
  output logic [NRD*XLEN-1:0]           rdata_o,
  output logic [NRD-1:0]                rbusy_o,
  input  logic                          sb_set_i,
  input  logic [$clog2(NREGS)-1:0]      sb_addr_i,
  input  logic                          jtag_req_i,
  input  logic                          jtag_we_i,
  input  logic [$clog2(NREGS)-1:0]      jtag_addr_i,
  input  logic [XLEN-1:0]               jtag_data_i,
  output logic                          jtag_ack_o,
  output logic [XLEN-1:0]               jtag_data_o,
  output logic                          jtag_hold_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  logic             core_wr;
  logic [AW-1:0]    j_addr;
  logic [XLEN-1:0]  j_rdata;
  logic             j_req;
  logic [XLEN-1:0]  j_wdata;
  logic             j_gnt;
  logic             jtag_wr;
  jtag_state_e      jtag_state;

  assign core_wr = (we_i == WriteEnable) && (waddr_i != AW'(ZeroReg));
  assign j_rdata = regs[j_addr];
  // The core owns the port on an address collision; the JTAG write retries next cycle.
  assign j_gnt   = (jtag_state == JTAG_EXEC) && !(we_i && waddr_i == j_addr);
  assign jtag_wr = j_req && j_gnt;

  regs_jtag_port #(
    .XLEN          (XLEN),
    .AW            (AW),
    .JTAG_WAIT_MAX (JTAG_WAIT_MAX)
  ) u_jtag (
    .clk       (clk),
    .rst       (rst),
    .jtag_req  (jtag_req_i),
    .jtag_we   (jtag_we_i),
    .jtag_addr (jtag_addr_i),
    .jtag_data (jtag_data_i),
    .jtag_ack  (jtag_ack_o),
    .rdata     (jtag_data_o),
    .hold      (jtag_hold_o),
    .acc_addr  (j_addr),
    .acc_rdata (j_rdata),
    .wr_req    (j_req),
    .wr_data   (j_wdata),
    .wr_gnt    (j_gnt),
    .state     (jtag_state)
  );

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (core_wr) regs[waddr_i] <= wdata_i;
      if (jtag_wr) regs[j_addr]  <= j_wdata;
    end
  end

  // Set is applied last so an issue in the same cycle as a writeback keeps the bit busy.
  always_comb begin
    busy_next = busy;
    if (core_wr) busy_next[waddr_i] = 1'b0;
    if (jtag_wr) busy_next[j_addr]  = 1'b0;
    if (sb_set_i && sb_addr_i != AW'(ZeroReg)) busy_next[sb_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr_i[k*AW +: AW];
    assign hit = we_i && (waddr_i == ra);

    always_comb begin
      if (ra == AW'(ZeroReg)) begin
        rdata_o[k*XLEN +: XLEN] = XLEN'(ZeroWord);
        rbusy_o[k]              = 1'b0;
      end else begin
        rdata_o[k*XLEN +: XLEN] = hit ? wdata_i : regs[ra];
        rbusy_o[k]              = busy[ra] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_regs_mp_sb.sv
// Scoreboard bench for regs_mp_sb: directed scenarios plus random traffic against a behavioural model.
module tb_regs_mp_sb;
  import regs_mp_sb_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int WMAX  = 8;
  localparam int EW    = 2*XLEN + NRD + 1;

  localparam int J_IDLE = 0;
  localparam int J_EXEC = 1;
  localparam int J_WAIT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                we_i = 1'b0;
  logic [AW-1:0]       waddr_i = '0;
  logic [XLEN-1:0]     wdata_i = '0;
  logic [NRD*AW-1:0]   raddr_i = '0;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic                sb_set_i = 1'b0;
  logic [AW-1:0]       sb_addr_i = '0;
  logic                jtag_req_i = 1'b0;
  logic                jtag_we_i = 1'b0;
  logic [AW-1:0]       jtag_addr_i = '0;
  logic [XLEN-1:0]     jtag_data_i = '0;
  logic                jtag_ack_o;
  logic [XLEN-1:0]     jtag_data_o;
  logic                jtag_hold_o;

  always #5 clk = ~clk;

  regs_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .JTAG_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
    .sb_set_i(sb_set_i), .sb_addr_i(sb_addr_i),
    .jtag_req_i(jtag_req_i), .jtag_we_i(jtag_we_i), .jtag_addr_i(jtag_addr_i),
    .jtag_data_i(jtag_data_i), .jtag_ack_o(jtag_ack_o), .jtag_data_o(jtag_data_o),
    .jtag_hold_o(jtag_hold_o)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0]   exp_q[$];
  int              jx_cyc_q[$];
  logic [XLEN-1:0] jx_data_q[$];
  bit              jx_rd_q[$];

  // Reference model: architectural registers, busy bits, and the debugger-side access phase.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  int              m_jph;
  bit              m_jwe;
  int              m_jaddr;
  logic [XLEN-1:0] m_jdata;
  int              m_jack;
  int              m_jblk;

  bit              jreq;
  bit              jwe;
  int              jaddr;
  logic [XLEN-1:0] jdata;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(int ra, bit we, int wa, logic [XLEN-1:0] wd);
    if (ra == 0) return '0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  function automatic bit exp_busy(int ra, bit we, int wa);
    return (ra != 0) && m_busy[ra] && !(we && wa == ra);
  endfunction

  task automatic step(bit we, int wa, logic [XLEN-1:0] wd, int ra0, int ra1, bit sbs, int sba);
    logic [XLEN-1:0] e0, e1;
    bit b0, b1, eh, jwr;
    @(negedge clk);
    we_i = we; waddr_i = AW'(wa); wdata_i = wd;
    raddr_i = {AW'(ra1), AW'(ra0)};
    sb_set_i = sbs; sb_addr_i = AW'(sba);
    jtag_req_i = jreq; jtag_we_i = jwe; jtag_addr_i = AW'(jaddr); jtag_data_i = jdata;
    e0 = exp_rd(ra0, we, wa, wd);
    e1 = exp_rd(ra1, we, wa, wd);
    b0 = exp_busy(ra0, we, wa);
    b1 = exp_busy(ra1, we, wa);
    eh = 1'b0;
    jwr = 1'b0;
    if (m_jph == J_EXEC) begin
      if (!m_jwe) begin
        jx_cyc_q.push_back(cyc + 1); jx_data_q.push_back(m_regs[m_jaddr]); jx_rd_q.push_back(1'b1);
        m_jph = J_WAIT; m_jack = cyc + 1;
      end else if (m_jaddr == 0) begin
        jx_cyc_q.push_back(cyc + 1); jx_data_q.push_back('0); jx_rd_q.push_back(1'b0);
        m_jph = J_WAIT; m_jack = cyc + 1;
      end else begin
`ifdef REGS_JTAG_HOLD_EN
        eh = (m_jblk >= WMAX);
`endif
        if (we && wa == m_jaddr) begin
          m_jblk++;
        end else begin
          jwr = 1'b1;
          jx_cyc_q.push_back(cyc + 1); jx_data_q.push_back('0); jx_rd_q.push_back(1'b0);
          m_jph = J_WAIT; m_jack = cyc + 1;
        end
      end
    end else if (m_jph == J_IDLE && jreq) begin
      m_jph = J_EXEC; m_jwe = jwe; m_jaddr = jaddr; m_jdata = jdata; m_jblk = 0;
    end else if (m_jph == J_WAIT && !jreq && cyc > m_jack) begin
      m_jph = J_IDLE;
    end
    exp_q.push_back({eh, b1, b0, e1, e0});
    if (we && wa != 0) begin m_regs[wa] = wd; m_busy[wa] = 1'b0; end
    if (jwr) begin m_regs[m_jaddr] = m_jdata; m_busy[m_jaddr] = 1'b0; end
    if (sbs && sba != 0) m_busy[sba] = 1'b1;
  endtask

  task automatic idle(int ra0, int ra1);
    step(1'b0, 0, '0, ra0, ra1, 1'b0, 0);
  endtask

  // Keep req high until the expected ack has passed, then release it for two cycles.
  task automatic jtag_finish();
    for (int i = 0; i < 60; i++) begin
      if (m_jph == J_WAIT && cyc > m_jack) break;
      idle(0, 0);
    end
    jreq = 1'b0;
    idle(0, 0);
    idle(0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    jreq = 1'b0; jtag_req_i = 1'b0;
    we_i = 1'b0; sb_set_i = 1'b0;
    raddr_i = {AW'(6), AW'(3)};
    #2;
    check("reset_ack",   64'(jtag_ack_o),  64'd0);
    check("reset_jdata", 64'(jtag_data_o), 64'd0);
    check("reset_hold",  64'(jtag_hold_o), 64'd0);
    check("reset_rdata", 64'(rdata_o),     64'd0);
    check("reset_rbusy", 64'(rbusy_o),     64'd0);
    check("reset_state", 64'(dut.u_jtag.state), 64'(JTAG_IDLE));
    for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_jph = J_IDLE;
    jx_cyc_q.delete(); jx_data_q.delete(); jx_rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata0", 64'(rdata_o[XLEN-1:0]),    64'(e[XLEN-1:0]));
        check("rdata1", 64'(rdata_o[2*XLEN-1:XLEN]), 64'(e[2*XLEN-1:XLEN]));
        check("rbusy",  64'(rbusy_o),                64'(e[2*XLEN +: NRD]));
        check("hold",   64'(jtag_hold_o),            64'(e[EW-1]));
      end
      if (rst) begin
        if (jtag_ack_o) begin
          if (jx_cyc_q.size() == 0) begin
            check("jtag_ack_spurious", 64'(jtag_ack_o), 64'd0);
          end else begin
            check("jtag_ack_cycle", 64'(cyc), 64'(jx_cyc_q[0]));
            if (jx_rd_q[0]) check("jtag_rdata", 64'(jtag_data_o), 64'(jx_data_q[0]));
            void'(jx_cyc_q.pop_front()); void'(jx_data_q.pop_front()); void'(jx_rd_q.pop_front());
          end
        end else if (jx_cyc_q.size() > 0 && cyc > jx_cyc_q[0]) begin
          check("jtag_ack_missing", 64'(jtag_ack_o), 64'd1);
          void'(jx_cyc_q.pop_front()); void'(jx_data_q.pop_front()); void'(jx_rd_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int wa, ra0, ra1;
    m_jph = J_IDLE; m_jack = 0; m_jblk = 0;
    jreq = 1'b0; jwe = 1'b0; jaddr = 0; jdata = '0;
    do_reset();

    // Bypass on a same-cycle write, then the stored value, with x0 on port 1.
    step(1'b1, 5, 32'h11, 0, 0, 1'b0, 0);
    step(1'b1, 5, 32'hAA, 5, 0, 1'b0, 0);
    idle(5, 0);

    // Scoreboard set, clear by writeback, set-wins on collision.
    step(1'b0, 0, '0, 0, 0, 1'b1, 7);
    idle(7, 0);
    step(1'b1, 7, 32'h77, 7, 7, 1'b0, 0);
    idle(7, 0);
    step(1'b0, 0, '0, 0, 0, 1'b1, 9);
    step(1'b1, 9, 32'h99, 9, 0, 1'b1, 9);
    idle(9, 7);
    step(1'b0, 0, '0, 0, 0, 1'b1, 0);
    idle(0, 9);

    // JTAG read of x3 with req held five cycles.
    step(1'b1, 3, 32'hDEAD_BEEF, 0, 0, 1'b0, 0);
    jreq = 1'b1; jwe = 1'b0; jaddr = 3; jdata = '0;
    for (int i = 0; i < 5; i++) idle(3, 0);
    jtag_finish();

    // JTAG write to x4 colliding with three core writes to x4.
    jreq = 1'b1; jwe = 1'b1; jaddr = 4; jdata = 32'h1234;
    idle(0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 4, $urandom, 4, 0, 1'b0, 0);
    idle(4, 0);
    jtag_finish();
    idle(4, 0);

    // JTAG write to x0 completes without writing.
    jreq = 1'b1; jwe = 1'b1; jaddr = 0; jdata = 32'hFFFF_FFFF;
    idle(0, 0);
    jtag_finish();

    // Long blockage of a JTAG write to x8 (hold behaviour depends on the build).
    step(1'b0, 0, '0, 0, 0, 1'b1, 8);
    jreq = 1'b1; jwe = 1'b1; jaddr = 8; jdata = 32'hABCD;
    idle(8, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 8, $urandom, 8, 0, 1'b0, 0);
    step(1'b0, 0, '0, 8, 0, 1'b1, 8);
    jtag_finish();
    idle(8, 0);

    // Reset during a blocked JTAG write to x6.
    jreq = 1'b1; jwe = 1'b1; jaddr = 6; jdata = 32'h5555;
    idle(0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 6, 32'h66, 0, 0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) idle(6, 4);

    // Random traffic with interleaved JTAG accesses.
    for (int i = 0; i < 400; i++) begin
      if (jreq && m_jph == J_WAIT && cyc > m_jack && $urandom_range(0, 1) == 1) begin
        jreq = 1'b0;
      end else if (!jreq && m_jph == J_IDLE && $urandom_range(0, 3) == 0) begin
        jreq = 1'b1; jwe = 1'($urandom_range(0, 1));
        jaddr = $urandom_range(0, NREGS-1); jdata = $urandom;
      end
      wa  = $urandom_range(0, NREGS-1);
      ra0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREGS-1);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREGS-1);
      step(1'($urandom_range(0, 1)), wa, $urandom, ra0, ra1,
           1'($urandom_range(0, 2) == 0), $urandom_range(0, NREGS-1));
    end
    jtag_finish();
    for (int i = 0; i < 4; i++) idle(0, 0);
    check("jtag_queue_drained", 64'(jx_cyc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
